// File: rtl/qpmm_final_reduce.sv
// Final reduction stage of the BN254 quotient-pipelined Montgomery multiplier.
// Maps a redundant result Z (0 <= Z < BOUND*P) to the canonical residue Z mod P.
// It accepts one operand per cycle and has a fixed latency of SEGS+1 cycles.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_z/in_tag  operand in (unsigned Z plus sideband tag)
//   out_valid           result valid; out_z/out_tag/out_err hold when low
//   out_z               Z mod P (Z-(BOUND-1)*P when out_err = 1)
//   out_tag             tag of the operand producing out_z
//   out_err             operand violated the input bound (Z >= BOUND*P)
module qpmm_final_reduce #(
  parameter int unsigned W     = 256,
  parameter logic [W-1:0] P    = W'(256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47),
  parameter int unsigned BOUND = 4,
  parameter int unsigned SEGS  = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_z,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W-1:0]     out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int unsigned SEG_W = W / SEGS;
  localparam int unsigned XW    = W + 2;
  // Candidate k = BOUND is extra: if Z-BOUND*P does not borrow, then Z-(BOUND-1)*P >= P.
  localparam int unsigned NK    = BOUND + 1;

  logic [NK-1:0][W-1:0] cand;
  logic [NK-1:0]        ok;

  // One borrow-chain pipeline per candidate k; segment s is resolved in stage s.
  for (genvar k = 0; k < NK; k++) begin : g_cand
    localparam logic [XW-1:0] KPK = XW'(P) * XW'(k);

    logic [W-1:0]    src_a [SEGS];
    logic [SEGS-1:0] bin_a;
    logic [W-1:0]    d_n   [SEGS];
    logic [SEGS-1:0] b_n;
    logic [W-1:0]    d_q   [SEGS];
    logic [SEGS-1:0] b_q;
    logic [SEG_W:0]  diff;

    always_comb begin
      diff     = '0;
      bin_a    = '0;
      b_n      = '0;
      src_a[0] = in_z;
      for (int s = 1; s < SEGS; s++) begin
        src_a[s] = d_q[s-1];
        bin_a[s] = b_q[s-1];
      end
      for (int s = 0; s < SEGS; s++) begin
        diff   = {1'b0, src_a[s][s*SEG_W +: SEG_W]} - {1'b0, KPK[s*SEG_W +: SEG_W]}
                 - (SEG_W+1)'(bin_a[s]);
        d_n[s] = src_a[s];
        d_n[s][s*SEG_W +: SEG_W] = diff[SEG_W-1:0];
        b_n[s] = diff[SEG_W];
      end
    end

    // Data path runs freely; only the valid pipeline is reset.
    always_ff @(posedge clk) begin
      for (int s = 0; s < SEGS; s++) begin
        d_q[s] <= d_n[s];
      end
      b_q <= b_n;
    end

    // A constant with bits above W can never be subtracted without going negative.
    assign cand[k] = d_q[SEGS-1];
    assign ok[k]   = !b_q[SEGS-1] && (KPK[XW-1:W] == 2'b00);
  end

  logic [SEGS-1:0]  vld_q;
  logic [TAG_W-1:0] tag_q [SEGS];

  // Valid and tag travel in step with the borrow chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int s = 1; s < SEGS; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int s = 1; s < SEGS; s++) begin
      tag_q[s] <= tag_q[s-1];
    end
  end

  logic [W-1:0] sel_z_c;
  logic         sel_err_c;

  // Non-borrowing candidates form a prefix of k, so the last one seen is kmax.
  always_comb begin
    sel_z_c   = cand[0];
    sel_err_c = ok[BOUND];
    for (int k = 1; k < BOUND; k++) begin
      if (ok[k]) sel_z_c = cand[k];
    end
  end

  // Output register: loads only on valid results, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= vld_q[SEGS-1];
      if (vld_q[SEGS-1]) begin
        out_z   <= sel_z_c;
        out_tag <= tag_q[SEGS-1];
        out_err <= sel_err_c;
      end
    end
  end

endmodule

// File: tb/tb_qpmm_final_reduce.sv
// Directed and randomised bench for qpmm_final_reduce with a latency-tagged expectation queue.
module tb_qpmm_final_reduce;
  localparam int unsigned W     = 256;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned SEGS  = 4;
  localparam int          LAT   = SEGS + 1;
  localparam logic [W-1:0] P =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_z;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [W-1:0]     out_z;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  always #5 clk = ~clk;

  qpmm_final_reduce #(.W(W), .P(P), .BOUND(4), .SEGS(SEGS), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_z      (in_z),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_z     (out_z),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  typedef struct {
    int               due;
    logic [W-1:0]     z;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t             q[$];
  int               cyc = 0;
  int               n_pass = 0;
  int               n_fail = 0;
  int               n_total = 0;
  logic [W-1:0]     last_z;
  logic [TAG_W-1:0] last_tag;
  logic             last_err;

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", name, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the outputs just after the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] z,
                      input logic [TAG_W-1:0] t, input logic [W-1:0] ez, input logic ee);
    exp_t e;
    rst = r; in_valid = v; in_z = z; in_tag = t;
    if (v && !r) q.push_back('{cyc + LAT, ez, t, ee});
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      last_z = '0; last_tag = '0; last_err = 1'b0;
    end
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_valid", W'(out_valid), W'(1'b1));
      chk("out_z",     out_z,         e.z);
      chk("out_tag",   W'(out_tag),   W'(e.tag));
      chk("out_err",   W'(out_err),   W'(e.err));
      last_z = e.z; last_tag = e.tag; last_err = e.err;
    end else begin
      chk("idle_valid", W'(out_valid), W'(1'b0));
      chk("hold_z",     out_z,         last_z);
      chk("hold_tag",   W'(out_tag),   W'(last_tag));
      chk("hold_err",   W'(out_err),   W'(last_err));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] rand_z();
    logic [W-1:0]   r;
    logic [W+1:0]   m;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    m = (W+2)'(P) * (W+2)'(4);
    return W'((W+2)'(r) % m);
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] z);
    return z % P;
  endfunction

  initial begin
    logic [W-1:0] z;
    logic [W-1:0] ones;
    ones = '1;

    // Reset; outputs must read zero afterwards.
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    step(1'b1, 1'b1, '0, 8'd9, '0, 1'b0);

    // First operand after reset.
    step(1'b0, 1'b1, '0, 8'd1, '0, 1'b0);
    idle(6);

    // Back-to-back boundary operands.
    step(1'b0, 1'b1, P,             8'd0, '0,    1'b0);
    step(1'b0, 1'b1, P - 1,         8'd1, P - 1, 1'b0);
    step(1'b0, 1'b1, P + P + 7,     8'd2, 7,     1'b0);
    step(1'b0, 1'b1, P + P + P + P - 1, 8'd3, P - 1, 1'b0);
    idle(6);

    // Largest in-range multiple and an out-of-bound input.
    step(1'b0, 1'b1, P + P + P + 5, 8'h10, 5, 1'b0);
    step(1'b0, 1'b1, ones, 8'h11, ones - P - P - P, 1'b1);
    idle(6);

    // Valid pattern 1,0,1,1,0.
    for (int i = 0; i < 5; i++) begin
      logic v;
      v = (i == 0 || i == 2 || i == 3);
      z = rand_z();
      step(1'b0, v, z, TAG_W'(8'h20 + i), model(z), 1'b0);
    end
    idle(6);

    // Reset mid-flight drops in-flight operands and the same-cycle input.
    for (int i = 0; i < 3; i++) begin
      z = rand_z();
      step(1'b0, 1'b1, z, TAG_W'(8'h30 + i), model(z), 1'b0);
    end
    step(1'b1, 1'b1, P + 3, 8'h3f, 3, 1'b0);
    idle(7);
    z = rand_z();
    step(1'b0, 1'b1, z, 8'h40, model(z), 1'b0);
    idle(6);

    // Random stream with random gaps.
    for (int i = 0; i < 3000; i++) begin
      z = rand_z();
      step(1'b0, ($urandom_range(0, 9) < 6), z, TAG_W'($urandom), model(z), 1'b0);
    end
    idle(7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
